// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction fetch / prefetch stage.
package fetch_prefetch_unit_pkg;

    // Default geometry of the RV32I fetch path.
    localparam int FP_PC_W  = 9;
    localparam int FP_INS_W = 32;

    // Byte distance between sequential instructions.
    localparam int PC_STEP  = 4;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [FP_PC_W-1:0]  pc;
        logic [FP_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous FIFO of prefetched entries; flush wins over push/pop.
module fetch_queue
    import fetch_prefetch_unit_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL = DEPTH[AW:0];

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            w_pop;
    logic            w_push;

    // Pops on an empty queue are ignored; a push into a full queue is only
    // accepted when a pop frees a slot in the same cycle.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != C_FULL) || w_pop);

    // Pointer and occupancy bookkeeping; indices wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage: sequential instruction fetch into a prefetch queue feeding decode,
// with EX-stage redirects flushing the queue and any in-flight fetch.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int               PC_W     = 9,
    parameter int               INS_W    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_req,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [INS_W-1:0]            imem_rdata,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [PC_W-1:0]             id_pc,
    output logic [INS_W-1:0]            id_instr,
    output logic [$clog2(DEPTH):0]      q_count
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   C_DEPTH = DEPTH[CW:0];

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic             r_kill;
    logic [PC_W-1:0]  r_last_addr;
    logic [CW:0]      w_occupancy;
    logic             w_req;
    logic             w_push;
    logic             w_pop;
    entry_t           w_push_data;
    entry_t           w_head;
    logic [CW-1:0]    w_count;

    // A request reserves a queue slot for its response, so queued entries plus
    // the pending response may never exceed the queue depth.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_req       = !reset && !redirect_valid && (w_occupancy < C_DEPTH);

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;

    // Fetch PC, in-flight tracking and kill of a response made stale by a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_kill     <= 1'b0;
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
            end
        end
    end

    // Remember the address of each request so it can be paired with its response.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_last_addr <= r_fetch_pc;
        end
    end

    assign w_push            = r_inflight && !r_kill;
    assign w_push_data.pc    = r_last_addr;
    assign w_push_data.instr = imem_rdata;
    assign w_pop             = id_valid && id_ready;

    fetch_queue #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    // Head is presented combinationally; empty queue drives zeros.
    assign id_valid = (w_count != '0);
    assign id_pc    = id_valid ? w_head.pc    : '0;
    assign id_instr = id_valid ? w_head.instr : '0;
    assign q_count  = w_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for the fetch/prefetch unit; memory returns addr>>2.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [8:0]  id_pc;
    logic [31:0] id_instr;
    logic [2:0]  q_count;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_prefetch_unit #(
        .PC_W     (9),
        .INS_W    (32),
        .DEPTH    (4),
        .RESET_PC (9'h000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    // Instruction memory with one-cycle latency; garbage when not requested.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'(imem_addr >> 2);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges; returns at the start of cycle 0.
    task automatic apply_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
        n_chk++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", q_count); end
        n_chk++; if (id_pc !== 9'h0) begin n_fail++; $display("FAIL reset_pc got=%0h exp=0", id_pc); end
        n_chk++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%0h exp=0", id_instr); end
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            #1;
            n_chk++; if (imem_req !== 1'b1 || imem_addr !== 9'(4*c)) begin
                n_fail++; $display("FAIL stream_req c=%0d got req=%0b addr=%0h exp req=1 addr=%0h", c, imem_req, imem_addr, 4*c);
            end
            if (c < 2) begin
                n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early c=%0d got valid=%0b exp=0", c, id_valid); end
            end else begin
                n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'(4*(c-2)) || id_instr !== 32'(c-2)) begin
                    n_fail++; $display("FAIL stream_head c=%0d got v=%0b pc=%0h ins=%0h exp v=1 pc=%0h ins=%0h", c, id_valid, id_pc, id_instr, 4*(c-2), c-2);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        id_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            n_chk++; if (imem_req !== (c < 4)) begin n_fail++; $display("FAIL full_req c=%0d got=%0b exp=%0b", c, imem_req, (c < 4)); end
            tick();
        end
        // cycle 10
        #1;
        n_chk++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", q_count); end
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'h0 || id_instr !== 32'h0) begin
            n_fail++; $display("FAIL full_head got v=%0b pc=%0h ins=%0h exp v=1 pc=0 ins=0", id_valid, id_pc, id_instr);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'(4*k) || id_instr !== 32'(k)) begin
                n_fail++; $display("FAIL full_drain k=%0d got v=%0b pc=%0h exp pc=%0h", k, id_valid, id_pc, 4*k);
            end
            if (k == 1) begin
                n_chk++; if (imem_req !== 1'b1 || imem_addr !== 9'h10) begin
                    n_fail++; $display("FAIL full_resume got req=%0b addr=%0h exp req=1 addr=10", imem_req, imem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        bit seen;
        id_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 4; c++) tick();
        // cycle 4: three queued, one response in flight
        redirect_valid = 1'b1;
        redirect_pc = 9'h043;
        id_ready = 1'b1;
        #1;
        n_chk++; if (q_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got=%0d exp=3", q_count); end
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req got=%0b exp=0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_flush got count=%0d v=%0b exp count=0 v=0", q_count, id_valid);
        end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 9'h040) begin
            n_fail++; $display("FAIL redir_target got req=%0b addr=%0h exp req=1 addr=40", imem_req, imem_addr);
        end
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            tick();
            #1;
            if (id_valid === 1'b1) seen = 1'b1;
        end
        n_chk++; if (!seen || id_pc !== 9'h040 || id_instr !== 32'h10) begin
            n_fail++; $display("FAIL redir_first got seen=%0b pc=%0h ins=%0h exp pc=40 ins=10", seen, id_pc, id_instr);
        end
        tick();
        #1;
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'h044) begin
            n_fail++; $display("FAIL redir_second got v=%0b pc=%0h exp v=1 pc=44", id_valid, id_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_pc;
        int got;
        id_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 5; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 9'h080;
        tick();
        redirect_pc = 9'h0C0;
        #1;
        n_chk++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL b2b_mid got v=%0b req=%0b exp v=0 req=0", id_valid, imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 9'h0C0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL b2b_target got req=%0b addr=%0h exp req=1 addr=c0", imem_req, imem_addr);
        end
        exp_pc = 9'h0C0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #1;
            if (id_valid === 1'b1) begin
                n_chk++; if (id_pc !== exp_pc) begin
                    n_fail++; $display("FAIL b2b_seq got pc=%0h exp pc=%0h", id_pc, exp_pc);
                end
                exp_pc = exp_pc + 9'd4;
                got++;
            end
            tick();
        end
        n_chk++; if (got < 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp>=4", got); end
    endtask

    task automatic test_wrap();
        bit seen;
        id_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 9'h1FC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 9'h1FC) begin n_fail++; $display("FAIL wrap_last got=%0h exp=1fc", imem_addr); end
        tick();
        #1;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin
            n_fail++; $display("FAIL wrap_addr got req=%0b addr=%0h exp req=1 addr=0", imem_req, imem_addr);
        end
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            if (id_valid === 1'b1) seen = 1'b1;
            else begin tick(); #1; end
        end
        n_chk++; if (!seen || id_pc !== 9'h1FC || id_instr !== 32'h7F) begin
            n_fail++; $display("FAIL wrap_head0 got seen=%0b pc=%0h ins=%0h exp pc=1fc ins=7f", seen, id_pc, id_instr);
        end
        tick();
        #1;
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'h000 || id_instr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_head1 got v=%0b pc=%0h ins=%0h exp v=1 pc=0 ins=0", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_mid_reset();
        id_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 3; c++) tick();
        // cycle 3: two queued, one response in flight
        #1;
        n_chk++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL mrst_pre got=%0d exp=2", q_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_chk++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin
            n_fail++; $display("FAIL mrst_clear got v=%0b count=%0d exp v=0 count=0", id_valid, q_count);
        end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin
            n_fail++; $display("FAIL mrst_restart got req=%0b addr=%0h exp req=1 addr=0", imem_req, imem_addr);
        end
        tick();
        #1;
        n_chk++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL mrst_drop got=%0d exp=0", q_count); end
        tick();
        #1;
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 9'h000 || q_count !== 3'd1) begin
            n_fail++; $display("FAIL mrst_first got v=%0b pc=%0h count=%0d exp v=1 pc=0 count=1", id_valid, id_pc, q_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
